pciecfg_mgmt_ctrl: RTL and testbench

Consumer stage behind the inbound PCIe-config request FIFO. It pops one `FIFO_PCIECFG_T` request at a time and executes it on the 7-series PCIe core configuration management port (`cfg_mgmt_*`). It bounds each access with a timeout and pushes one `FIFO_PCIECFG_RESP_T` per request into the outbound response FIFO. It runs entirely in the PCIe user clock domain.

---
 rtl/pciecfg_pkg.sv | 52 +++++
 rtl/pciecfg_mgmt_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_pciecfg_mgmt_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pciecfg_pkg.sv
// -----------------------------------------------------------------------------
// pciecfg_pkg
//
// Shared types for the PCIe configuration-management path.
//
//   FIFO_PCIECFG_T       request word carried by the inbound request FIFO.
//                        Field order, MSB first: tag, we, be, addr, data.
//   FIFO_PCIECFG_RESP_T  response word carried by the outbound response FIFO.
//                        Field order, MSB first: tag, we, status, data.
//   PCIECFG_ST_*         response status codes.
//   pciecfg_make_resp    builds a response word from its fields.
// -----------------------------------------------------------------------------
package pciecfg_pkg;

  // Request: one DWORD access to the core's configuration space.
  typedef struct packed {
    logic [7:0]  tag;   // echoed back in the response
    logic        we;    // 1 = write, 0 = read
    logic [3:0]  be;    // byte enables for the DWORD
    logic [9:0]  addr;  // DWORD address
    logic [31:0] data;  // write data (ignored for reads)
  } FIFO_PCIECFG_T;

  // Response: exactly one per request, in request order.
  typedef struct packed {
    logic [7:0]  tag;
    logic        we;
    logic [1:0]  status;
    logic [31:0] data;  // read data, 0 for writes, all-ones on timeout
  } FIFO_PCIECFG_RESP_T;

  localparam logic [1:0] PCIECFG_ST_OK      = 2'd0;
  localparam logic [1:0] PCIECFG_ST_TIMEOUT = 2'd1;

  // Read data returned when the core never completes the access.
  localparam logic [31:0] PCIECFG_TIMEOUT_DATA = 32'hFFFF_FFFF;

  function automatic FIFO_PCIECFG_RESP_T pciecfg_make_resp(
    input logic [7:0]  tag,
    input logic        we,
    input logic [1:0]  status,
    input logic [31:0] data
  );
    FIFO_PCIECFG_RESP_T r;
    r.tag    = tag;
    r.we     = we;
    r.status = status;
    r.data   = data;
    return r;
  endfunction

endpackage

// File: rtl/pciecfg_mgmt_ctrl.sv
// -----------------------------------------------------------------------------
// pciecfg_mgmt_ctrl
//
// Consumer stage behind the inbound PCIe-config request FIFO. Pops one request
// at a time, executes it on the 7-series PCIe core cfg_mgmt_* port, bounds the
// access with a timeout and pushes one response per request into the outbound
// response FIFO. Single clock domain (PCIe user clock).
//
// Handshake rules (all three interfaces):
//   * Inbound FIFO: a pop is in_rd_en high for one cycle while !in_empty;
//     in_dout is valid in the cycle after the pop.
//   * Outbound FIFO: a push is out_wr_en high for one cycle; it is only issued
//     when out_full was low in the cycle the push was decided. While out_full
//     is high nothing is pushed and nothing is popped.
//   * Core: exactly one of cfg_mgmt_rd_en / cfg_mgmt_wr_en is held high with
//     addr/di/byte_en stable until cfg_mgmt_rd_wr_done is sampled high (or the
//     timeout expires). rd_wr_done outside an access is ignored.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_dout/in_empty/in_rd_en      inbound request FIFO (read side)
//   out_din/out_wr_en/out_full     outbound response FIFO (write side)
//   cfg_mgmt_*             PCIe core configuration management port
//   req_count              responses pushed (wraps)
//   timeout_count          timed-out accesses (saturates at 16'hFFFF)
//   dbg_state              current FSM state (IDLE=0, FETCH=1, ACCESS=2, RESP=3)
// -----------------------------------------------------------------------------
module pciecfg_mgmt_ctrl
  import pciecfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [$bits(FIFO_PCIECFG_T)-1:0]      in_dout,
  input  logic                                  in_empty,
  output logic                                  in_rd_en,
  output logic [$bits(FIFO_PCIECFG_RESP_T)-1:0] out_din,
  output logic                                  out_wr_en,
  input  logic                                  out_full,
  output logic [9:0]                            cfg_mgmt_addr,
  output logic [31:0]                           cfg_mgmt_di,
  output logic [3:0]                            cfg_mgmt_byte_en,
  output logic                                  cfg_mgmt_rd_en,
  output logic                                  cfg_mgmt_wr_en,
  output logic                                  cfg_mgmt_wr_readonly,
  input  logic [31:0]                           cfg_mgmt_do,
  input  logic                                  cfg_mgmt_rd_wr_done,
  output logic [31:0]                           req_count,
  output logic [15:0]                           timeout_count,
  output logic [1:0]                            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counter value in the last cycle the strobe may stay high. The counter is
  // 0 in the first strobe cycle, so the strobe is high TIMEOUT_CYCLES cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state_q,         state_d;
  logic               in_rd_en_q,      in_rd_en_d;
  FIFO_PCIECFG_RESP_T out_din_q,       out_din_d;
  logic               out_wr_en_q,     out_wr_en_d;
  logic [9:0]         addr_q,          addr_d;
  logic [31:0]        di_q,            di_d;
  logic [3:0]         be_q,            be_d;
  logic               rd_en_q,         rd_en_d;
  logic               wr_en_q,         wr_en_d;
  logic [7:0]         tag_q,           tag_d;
  logic               we_q,            we_d;
  logic [TO_W-1:0]    to_cnt_q,        to_cnt_d;
  logic [31:0]        req_count_q,     req_count_d;
  logic [15:0]        timeout_count_q, timeout_count_d;

  FIFO_PCIECFG_T req;
  assign req = FIFO_PCIECFG_T'(in_dout);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    in_rd_en_d      = 1'b0;
    out_wr_en_d     = 1'b0;
    out_din_d       = out_din_q;
    addr_d          = addr_q;
    di_d            = di_q;
    be_d            = be_q;
    rd_en_d         = rd_en_q;
    wr_en_d         = wr_en_q;
    tag_d           = tag_q;
    we_d            = we_q;
    to_cnt_d        = to_cnt_q;
    req_count_d     = req_count_q;
    timeout_count_d = timeout_count_q;

    case (state_q)
      ST_IDLE: begin
        if (!in_empty) begin
          in_rd_en_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // The first FETCH cycle is the pop cycle itself; in_dout only becomes
        // valid one cycle later, so the request is latched when the pop has
        // dropped. Latching it also raises the strobe, giving pop-to-strobe
        // of two cycles.
        if (!in_rd_en_q) begin
          tag_d    = req.tag;
          we_d     = req.we;
          addr_d   = req.addr;
          di_d     = req.data;
          be_d     = req.be;
          rd_en_d  = !req.we;
          wr_en_d  = req.we;
          to_cnt_d = '0;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // done is checked before the timeout so a completion landing in the
        // final timeout cycle still returns OK with its data.
        if (cfg_mgmt_rd_wr_done) begin
          rd_en_d   = 1'b0;
          wr_en_d   = 1'b0;
          out_din_d = pciecfg_make_resp(tag_q, we_q, PCIECFG_ST_OK,
                                        we_q ? 32'h0 : cfg_mgmt_do);
          state_d   = ST_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rd_en_d   = 1'b0;
          wr_en_d   = 1'b0;
          out_din_d = pciecfg_make_resp(tag_q, we_q, PCIECFG_ST_TIMEOUT,
                                        PCIECFG_TIMEOUT_DATA);
          if (timeout_count_q != 16'hFFFF) begin
            timeout_count_d = timeout_count_q + 16'd1;
          end
          state_d   = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        // The push is decided in the same cycle the access ends, so out_wr_en
        // rises together with the strobe falling when the FIFO has room.
        if (state_d == ST_RESP && !out_full) begin
          out_wr_en_d = 1'b1;
          req_count_d = req_count_q + 32'd1;
        end
      end

      ST_RESP: begin
        // out_wr_en_q high means the push is happening this cycle; the next
        // pop may only be issued after that, keeping one request outstanding.
        if (out_wr_en_q) begin
          state_d = ST_IDLE;
        end else if (!out_full) begin
          out_wr_en_d = 1'b1;
          req_count_d = req_count_q + 32'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      in_rd_en_q      <= 1'b0;
      out_din_q       <= '0;
      out_wr_en_q     <= 1'b0;
      addr_q          <= '0;
      di_q            <= '0;
      be_q            <= '0;
      rd_en_q         <= 1'b0;
      wr_en_q         <= 1'b0;
      tag_q           <= '0;
      we_q            <= 1'b0;
      to_cnt_q        <= '0;
      req_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      in_rd_en_q      <= in_rd_en_d;
      out_din_q       <= out_din_d;
      out_wr_en_q     <= out_wr_en_d;
      addr_q          <= addr_d;
      di_q            <= di_d;
      be_q            <= be_d;
      rd_en_q         <= rd_en_d;
      wr_en_q         <= wr_en_d;
      tag_q           <= tag_d;
      we_q            <= we_d;
      to_cnt_q        <= to_cnt_d;
      req_count_q     <= req_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_rd_en             = in_rd_en_q;
  assign out_din              = out_din_q;
  assign out_wr_en            = out_wr_en_q;
  assign cfg_mgmt_addr        = addr_q;
  assign cfg_mgmt_di          = di_q;
  assign cfg_mgmt_byte_en     = be_q;
  assign cfg_mgmt_rd_en       = rd_en_q;
  assign cfg_mgmt_wr_en       = wr_en_q;
  assign cfg_mgmt_wr_readonly = 1'b0;
  assign req_count            = req_count_q;
  assign timeout_count        = timeout_count_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_pciecfg_mgmt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pciecfg_mgmt_ctrl
//
// Directed bench for pciecfg_mgmt_ctrl with TIMEOUT_CYCLES = 16. An array
// models the inbound FIFO, a small behavioural core answers strobes after
// core_lat cycles, and each scenario task compares the responses against
// hand-computed words built as {tag, we, status, data}.
// -----------------------------------------------------------------------------
module tb_pciecfg_mgmt_ctrl;

  localparam int TO = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic [54:0] in_dout = '0;
  logic        in_empty;
  logic        in_rd_en;
  logic [42:0] out_din;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [9:0]  cfg_mgmt_addr;
  logic [31:0] cfg_mgmt_di;
  logic [3:0]  cfg_mgmt_byte_en;
  logic        cfg_mgmt_rd_en;
  logic        cfg_mgmt_wr_en;
  logic        cfg_mgmt_wr_readonly;
  logic [31:0] cfg_mgmt_do = '0;
  logic        cfg_mgmt_rd_wr_done = 1'b0;
  logic [31:0] req_count;
  logic [15:0] timeout_count;
  logic [1:0]  dbg_state;

  pciecfg_mgmt_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_dout              (in_dout),
    .in_empty             (in_empty),
    .in_rd_en             (in_rd_en),
    .out_din              (out_din),
    .out_wr_en            (out_wr_en),
    .out_full             (out_full),
    .cfg_mgmt_addr        (cfg_mgmt_addr),
    .cfg_mgmt_di          (cfg_mgmt_di),
    .cfg_mgmt_byte_en     (cfg_mgmt_byte_en),
    .cfg_mgmt_rd_en       (cfg_mgmt_rd_en),
    .cfg_mgmt_wr_en       (cfg_mgmt_wr_en),
    .cfg_mgmt_wr_readonly (cfg_mgmt_wr_readonly),
    .cfg_mgmt_do          (cfg_mgmt_do),
    .cfg_mgmt_rd_wr_done  (cfg_mgmt_rd_wr_done),
    .req_count            (req_count),
    .timeout_count        (timeout_count),
    .dbg_state            (dbg_state)
  );

  // Inbound FIFO model: data appears the cycle after a pop.
  logic [54:0] in_mem [0:63];
  int in_wp = 0;
  int in_rp = 0;
  assign in_empty = (in_wp == in_rp);
  always @(posedge clk) begin
    if (in_rd_en && (in_wp != in_rp)) begin
      in_dout <= in_mem[in_rp % 64];
      in_rp   <= in_rp + 1;
    end
  end

  // Core model: done in the core_lat-th consecutive strobe cycle.
  int core_lat = 2;
  bit core_en  = 1'b1;
  int core_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
      core_cnt            = core_cnt + 1;
      cfg_mgmt_rd_wr_done = core_en && (core_cnt == core_lat);
    end else begin
      core_cnt            = 0;
      cfg_mgmt_rd_wr_done = 1'b0;
    end
  end

  // Bookkeeping
  int errors = 0;
  int checks = 0;

  // Results of the last wait_resp call
  logic [42:0] w_resp;
  logic [9:0]  w_addr;
  logic [31:0] w_di;
  logic [3:0]  w_be;
  bit          w_got;
  bit          w_both;
  int          w_rd, w_wr, w_pop, w_stb, w_push;

  task automatic push_req(input logic [7:0] tag, input logic we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] data);
    in_mem[in_wp % 64] = {tag, we, be, addr, data};
    in_wp = in_wp + 1;
  endtask

  // Waits (bounded) for the next push, recording strobe activity on the way.
  task automatic wait_resp();
    w_got = 0; w_both = 0; w_rd = 0; w_wr = 0;
    w_pop = -1; w_stb = -1; w_push = -1;
    w_resp = '0; w_addr = '0; w_di = '0; w_be = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_rd_en && w_pop < 0) w_pop = cyc;
      if (cfg_mgmt_rd_en && cfg_mgmt_wr_en) w_both = 1;
      if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
        if (w_stb < 0) begin
          w_stb  = cyc;
          w_addr = cfg_mgmt_addr;
          w_di   = cfg_mgmt_di;
          w_be   = cfg_mgmt_byte_en;
        end
        w_rd = w_rd + int'(cfg_mgmt_rd_en);
        w_wr = w_wr + int'(cfg_mgmt_wr_en);
      end
      if (out_wr_en) begin
        w_resp = out_din;
        w_push = cyc;
        w_got  = 1;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    checks++; if ({in_rd_en, out_wr_en, cfg_mgmt_rd_en, cfg_mgmt_wr_en, cfg_mgmt_wr_readonly} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b exp 00000", {in_rd_en, out_wr_en, cfg_mgmt_rd_en, cfg_mgmt_wr_en, cfg_mgmt_wr_readonly}); end
    checks++; if ({out_din, cfg_mgmt_addr, cfg_mgmt_di, cfg_mgmt_byte_en} !== 89'b0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", {out_din, cfg_mgmt_addr, cfg_mgmt_di, cfg_mgmt_byte_en}); end
    checks++; if (req_count !== 32'd0 || timeout_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got req=%0d to=%0d exp 0 0", req_count, timeout_count); end
  endtask

  task automatic test_read();
    core_lat = 2; core_en = 1; cfg_mgmt_do = 32'h0010_0107;
    push_req(8'h12, 1'b0, 4'hF, 10'h004, 32'h0);
    wait_resp();
    checks++; if (w_resp !== {8'h12, 1'b0, 2'd0, 32'h0010_0107}) begin errors++; $display("FAIL read_resp: got %h exp %h got_flag=%0d", w_resp, {8'h12, 1'b0, 2'd0, 32'h0010_0107}, w_got); end
    checks++; if (w_rd !== 2 || w_wr !== 0) begin errors++; $display("FAIL read_strobe_len: got rd=%0d wr=%0d exp 2 0", w_rd, w_wr); end
    checks++; if (w_stb - w_pop !== 2) begin errors++; $display("FAIL read_pop_to_strobe: got %0d exp 2", w_stb - w_pop); end
    checks++; if (w_push - w_stb !== 2) begin errors++; $display("FAIL read_strobe_to_push: got %0d exp 2", w_push - w_stb); end
    checks++; if (w_addr !== 10'h004 || w_be !== 4'hF) begin errors++; $display("FAIL read_addr_be: got %h %h exp 004 f", w_addr, w_be); end
    @(negedge clk);
    checks++; if (req_count !== 32'd1) begin errors++; $display("FAIL read_req_count: got %0d exp 1", req_count); end
    idle_cycles(3);
  endtask

  task automatic test_write();
    core_lat = 3; core_en = 1; cfg_mgmt_do = 32'h5555_AAAA;
    push_req(8'h34, 1'b1, 4'h3, 10'h001, 32'h0000_0006);
    wait_resp();
    checks++; if (w_resp !== {8'h34, 1'b1, 2'd0, 32'h0}) begin errors++; $display("FAIL write_resp: got %h exp %h", w_resp, {8'h34, 1'b1, 2'd0, 32'h0}); end
    checks++; if (w_wr !== 3 || w_rd !== 0) begin errors++; $display("FAIL write_strobe_len: got wr=%0d rd=%0d exp 3 0", w_wr, w_rd); end
    checks++; if (w_di !== 32'h6 || w_be !== 4'h3 || w_addr !== 10'h001) begin errors++; $display("FAIL write_fields: got di=%h be=%h addr=%h exp 6 3 1", w_di, w_be, w_addr); end
    @(negedge clk);
    checks++; if (req_count !== 32'd2) begin errors++; $display("FAIL write_req_count: got %0d exp 2", req_count); end
    idle_cycles(3);
  endtask

  task automatic test_timeout();
    core_en = 0;
    push_req(8'h56, 1'b0, 4'hF, 10'h007, 32'h0);
    wait_resp();
    checks++; if (w_resp !== {8'h56, 1'b0, 2'd1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL timeout_resp: got %h exp %h", w_resp, {8'h56, 1'b0, 2'd1, 32'hFFFF_FFFF}); end
    checks++; if (w_rd !== TO) begin errors++; $display("FAIL timeout_strobe_len: got %0d exp %0d", w_rd, TO); end
    checks++; if (w_push - w_stb !== TO) begin errors++; $display("FAIL timeout_strobe_to_push: got %0d exp %0d", w_push - w_stb, TO); end
    @(negedge clk);
    checks++; if (timeout_count !== 16'd1 || req_count !== 32'd3) begin errors++; $display("FAIL timeout_counts: got to=%0d req=%0d exp 1 3", timeout_count, req_count); end
    core_en = 1;
    idle_cycles(3);
  endtask

  task automatic test_done_at_timeout();
    core_lat = TO; core_en = 1; cfg_mgmt_do = 32'hCAFE_0001;
    push_req(8'h78, 1'b0, 4'hF, 10'h00A, 32'h0);
    wait_resp();
    checks++; if (w_resp !== {8'h78, 1'b0, 2'd0, 32'hCAFE_0001}) begin errors++; $display("FAIL done_at_to_resp: got %h exp %h", w_resp, {8'h78, 1'b0, 2'd0, 32'hCAFE_0001}); end
    checks++; if (w_rd !== TO) begin errors++; $display("FAIL done_at_to_strobe_len: got %0d exp %0d", w_rd, TO); end
    @(negedge clk);
    checks++; if (timeout_count !== 16'd1 || req_count !== 32'd4) begin errors++; $display("FAIL done_at_to_counts: got to=%0d req=%0d exp 1 4", timeout_count, req_count); end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    int pops, pushes, p1, p2;
    logic [42:0] exp_q[$];
    core_lat = 1; core_en = 1; cfg_mgmt_do = 32'h1234_5678;
    out_full = 1'b1;
    push_req(8'hA1, 1'b1, 4'hF, 10'h010, 32'h1);
    push_req(8'hA2, 1'b0, 4'hF, 10'h011, 32'h0);
    push_req(8'hA3, 1'b1, 4'h1, 10'h012, 32'h3);
    exp_q.push_back({8'hA1, 1'b1, 2'd0, 32'h0});
    exp_q.push_back({8'hA2, 1'b0, 2'd0, 32'h1234_5678});
    exp_q.push_back({8'hA3, 1'b1, 2'd0, 32'h0});
    pops = 0; pushes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pops   = pops + int'(in_rd_en);
      pushes = pushes + int'(out_wr_en);
    end
    checks++; if (pops !== 1 || pushes !== 0) begin errors++; $display("FAIL bp_stall: got pops=%0d pushes=%0d exp 1 0", pops, pushes); end
    checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL bp_state: got %0d exp 3", dbg_state); end
    out_full = 1'b0;
    p1 = 0; p2 = 0;
    for (int k = 0; k < 3; k++) begin
      logic [42:0] exp;
      exp = exp_q.pop_front();
      wait_resp();
      checks++; if (w_resp !== exp) begin errors++; $display("FAIL bp_resp%0d: got %h exp %h", k, w_resp, exp); end
      if (k == 0) p1 = w_push;
      if (k == 1) begin
        checks++; if (w_push - p1 !== 5) begin errors++; $display("FAIL bp_spacing1: got %0d exp 5", w_push - p1); end
        p2 = w_push;
      end
      if (k == 2) begin
        checks++; if (w_push - p2 !== 5) begin errors++; $display("FAIL bp_spacing2: got %0d exp 5", w_push - p2); end
      end
    end
    @(negedge clk);
    checks++; if (req_count !== 32'd7) begin errors++; $display("FAIL bp_req_count: got %0d exp 7", req_count); end
    idle_cycles(3);
  endtask

  task automatic test_reset_mid_access();
    int n;
    core_en = 0; core_lat = 2;
    push_req(8'h9A, 1'b0, 4'hF, 10'h020, 32'h0);
    push_req(8'h9B, 1'b1, 4'hC, 10'h3FF, 32'hDEAD_BEEF);
    n = 0;
    while (!cfg_mgmt_rd_en && n < 50) begin @(negedge clk); n++; end
    checks++; if (cfg_mgmt_rd_en !== 1'b1) begin errors++; $display("FAIL rstmid_strobe_seen: got %b exp 1", cfg_mgmt_rd_en); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cfg_mgmt_rd_en !== 1'b0 || cfg_mgmt_wr_en !== 1'b0 || out_wr_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_strobes: got rd=%b wr=%b push=%b exp 0 0 0", cfg_mgmt_rd_en, cfg_mgmt_wr_en, out_wr_en); end
    checks++; if (dbg_state !== 2'd0 || req_count !== 32'd0 || timeout_count !== 16'd0) begin
      errors++; $display("FAIL rstmid_state: got st=%0d req=%0d to=%0d exp 0 0 0", dbg_state, req_count, timeout_count); end
    rst = 1'b0;
    core_en = 1;
    wait_resp();
    checks++; if (w_resp !== {8'h9B, 1'b1, 2'd0, 32'h0}) begin errors++; $display("FAIL rstmid_resp: got %h exp %h", w_resp, {8'h9B, 1'b1, 2'd0, 32'h0}); end
    checks++; if (w_wr !== 2 || w_di !== 32'hDEAD_BEEF || w_be !== 4'hC || w_addr !== 10'h3FF) begin
      errors++; $display("FAIL rstmid_fields: got wr=%0d di=%h be=%h addr=%h exp 2 deadbeef c 3ff", w_wr, w_di, w_be, w_addr); end
    @(negedge clk);
    checks++; if (req_count !== 32'd1) begin errors++; $display("FAIL rstmid_req_count: got %0d exp 1", req_count); end
    idle_cycles(3);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle_cycles(3);
    test_reset();
    rst = 1'b0;
    idle_cycles(2);
    test_read();
    test_write();
    test_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
